// File: rtl/frame_ram_pkg.sv
// Shared constants and types for the frame RAM arbiter.
// Holds the default image geometry, pixel/address widths, the arbiter
// state encoding and the total frame size in pixels.
package frame_ram_pkg;

    localparam int IMG_W        = 512;
    localparam int IMG_H        = 384;
    localparam int PIX_W        = 24;
    localparam int ADDR_W       = 18;
    localparam int FRAME_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/frame_wr_fifo.sv
// Small write-request FIFO placed between the pixel writer and the arbiter.
// Ports: clk/rst (async active-low), push/din (enqueue), pop/dout (dequeue,
// dout shows the head entry), full/empty status.
// DEPTH must be a power of two so the pointers wrap naturally.
module frame_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    // Guarded locally too, so a full FIFO can never be overwritten.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Frame RAM arbiter: shares one synchronous single-port RAM between the
// display scan-out (absolute priority) and a pixel writer.
// Ports: clk, rst (async active-low); pos_x/pos_y display position and
// pix_out pixel (3-cycle latency); wr_valid/wr_ready/wr_addr/wr_data writer
// handshake; ram_addr/ram_we/ram_din/ram_dout RAM port (1-cycle read);
// wr_err sticky out-of-range write flag.
// Build option: define FRAME_WR_FIFO_EN to buffer writes in a 4-entry FIFO
// so the writer is not stalled by the active display window.
module frame_ram_arbiter #(
    parameter int IMG_W  = frame_ram_pkg::IMG_W,
    parameter int IMG_H  = frame_ram_pkg::IMG_H,
    parameter int PIX_W  = frame_ram_pkg::PIX_W,
    parameter int ADDR_W = frame_ram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    output logic [PIX_W-1:0]  pix_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_din,
    input  logic [PIX_W-1:0]  ram_dout,
    output logic              wr_err
);
    import frame_ram_pkg::*;

    localparam logic [ADDR_W:0] FRAME_LIM = (ADDR_W+1)'(IMG_W * IMG_H);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [PIX_W-1:0]  ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              wr_err_q, wr_err_d;
    logic              vld2_q, vld2_d;
    logic [PIX_W-1:0]  pix_out_q, pix_out_d;

    logic              in_win;
    logic [ADDR_W-1:0] disp_addr;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_c_addr;
    logic [PIX_W-1:0]  wr_c_data;

    assign in_win = (int'(pos_x) >= 1) && (int'(pos_x) <= IMG_W) &&
                    (int'(pos_y) >= 1) && (int'(pos_y) <= IMG_H);
    // Computed modulo 2^ADDR_W, which equals truncating the full product.
    assign disp_addr = ADDR_W'(pos_x) - ADDR_W'(1) +
                       (ADDR_W'(pos_y) - ADDR_W'(1)) * ADDR_W'(IMG_W);

`ifdef FRAME_WR_FIFO_EN
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [ADDR_W+PIX_W-1:0] fifo_dout;

    assign wr_ready = rst & ~fifo_full;
    assign fifo_pop = ~in_win & ~fifo_empty;
    assign wr_pend  = ~fifo_empty;
    assign {wr_c_addr, wr_c_data} = fifo_dout;

    frame_wr_fifo #(
        .DEPTH (4),
        .W     (ADDR_W + PIX_W)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid & wr_ready),
        .din   ({wr_addr, wr_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    // Direct path: a pending write transfers on any out-of-window cycle.
    assign wr_ready  = rst & ~in_win;
    assign wr_pend   = wr_valid;
    assign wr_c_addr = wr_addr;
    assign wr_c_data = wr_data;
`endif

    always_comb begin
        state_d    = IDLE;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        wr_err_d   = wr_err_q;
        if (in_win) begin
            state_d    = RD;
            ram_addr_d = disp_addr;
        end else if (wr_pend) begin
            if ({1'b0, wr_c_addr} >= FRAME_LIM) begin
                // Consumed but dropped: no RAM cycle, just flag it.
                wr_err_d = 1'b1;
            end else begin
                state_d    = WR;
                ram_addr_d = wr_c_addr;
                ram_din_d  = wr_c_data;
                ram_we_d   = 1'b1;
            end
        end
        // Flag pipeline: stage 1 is state RD, stage 2 aligns with ram_dout,
        // stage 3 is folded into pix_out (zero when the sample was blank).
        vld2_d    = (state_q == RD);
        pix_out_d = vld2_q ? ram_dout : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            vld2_q     <= 1'b0;
            pix_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            wr_err_q   <= wr_err_d;
            vld2_q     <= vld2_d;
            pix_out_q  <= pix_out_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign wr_err   = wr_err_q;
    assign pix_out  = pix_out_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
module tb_frame_ram_arbiter;

    localparam int PIX_W  = 24;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [10:0]       pos_x = '0, pos_y = '0;
    logic [PIX_W-1:0]  pix_out;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [PIX_W-1:0]  wr_data = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [PIX_W-1:0]  ram_din;
    logic [PIX_W-1:0]  ram_dout = '0;
    logic              wr_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // RAM stand-in: read data is a fixed tag plus the address read last cycle.
    always @(posedge clk) ram_dout <= {6'h2A, ram_addr};

    frame_ram_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .pix_out  (pix_out),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .wr_err   (wr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int x, input int y);
        pos_x = 11'(x);
        pos_y = 11'(y);
    endtask

    task automatic test_reset();
        set_pos(0, 0);
        #2 rst = 1'b0;
        #1;
        total++; if (pix_out !== '0) $display("FAIL rst_pix got=%h exp=0", pix_out); else passed++;
        total++; if (ram_addr !== '0) $display("FAIL rst_addr got=%h exp=0", ram_addr); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", ram_we); else passed++;
        total++; if (ram_din !== '0) $display("FAIL rst_din got=%h exp=0", ram_din); else passed++;
        total++; if (wr_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", wr_ready); else passed++;
        total++; if (wr_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", wr_err); else passed++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_addr();
        set_pos(1, 1);
        tick();   // edge 1
        total++; if (ram_addr !== 18'd0) $display("FAIL rd_addr0 got=%0d exp=0", ram_addr); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL rd_we0 got=%b exp=0", ram_we); else passed++;
        set_pos(512, 384);
        tick();   // edge 2
        total++; if (ram_addr !== 18'd196607) $display("FAIL rd_addr1 got=%0d exp=196607", ram_addr); else passed++;
        total++; if (pix_out !== '0) $display("FAIL rd_pix_early got=%h exp=0", pix_out); else passed++;
        set_pos(0, 5);
        tick();   // edge 3: pixel for (1,1)
        total++; if (pix_out !== {6'h2A, 18'd0}) $display("FAIL rd_pix0 got=%h exp=%h", pix_out, {6'h2A, 18'd0}); else passed++;
        total++; if (ram_addr !== 18'd196607) $display("FAIL idle_hold got=%0d exp=196607", ram_addr); else passed++;
        set_pos(513, 1);
        tick();   // edge 4: pixel for (512,384)
        total++; if (pix_out !== {6'h2A, 18'd196607}) $display("FAIL rd_pix1 got=%h exp=%h", pix_out, {6'h2A, 18'd196607}); else passed++;
    endtask

    task automatic test_out_of_window();
        // (0,5) and (513,1) were presented on the last two cycles.
        set_pos(0, 0);
        tick();   // edge 5
        total++; if (pix_out !== '0) $display("FAIL oow_pix0 got=%h exp=0", pix_out); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL oow_we0 got=%b exp=0", ram_we); else passed++;
        tick();   // edge 6
        total++; if (pix_out !== '0) $display("FAIL oow_pix1 got=%h exp=0", pix_out); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL oow_we1 got=%b exp=0", ram_we); else passed++;
    endtask

    task automatic test_contention();
        set_pos(10, 10);
        wr_valid = 1'b1;
        wr_addr  = 18'd100;
        wr_data  = 24'hABCDEF;
        #1;
`ifdef FRAME_WR_FIFO_EN
        total++; if (wr_ready !== 1'b1) $display("FAIL cont_ready_win got=%b exp=1", wr_ready); else passed++;
        tick();
        wr_valid = 1'b0;
`else
        total++; if (wr_ready !== 1'b0) $display("FAIL cont_ready_win got=%b exp=0", wr_ready); else passed++;
        tick();
`endif
        total++; if (ram_we !== 1'b0) $display("FAIL cont_we_win got=%b exp=0", ram_we); else passed++;
        total++; if (ram_addr !== 18'd4617) $display("FAIL cont_rd_addr got=%0d exp=4617", ram_addr); else passed++;
        set_pos(0, 0);
`ifndef FRAME_WR_FIFO_EN
        #1;
        total++; if (wr_ready !== 1'b1) $display("FAIL cont_ready_blank got=%b exp=1", wr_ready); else passed++;
`endif
        tick();
        wr_valid = 1'b0;
        total++; if (ram_we !== 1'b1) $display("FAIL cont_we got=%b exp=1", ram_we); else passed++;
        total++; if (ram_addr !== 18'd100) $display("FAIL cont_addr got=%0d exp=100", ram_addr); else passed++;
        total++; if (ram_din !== 24'hABCDEF) $display("FAIL cont_din got=%h exp=abcdef", ram_din); else passed++;
        tick();
        total++; if (ram_we !== 1'b0) $display("FAIL cont_we_once got=%b exp=0", ram_we); else passed++;
    endtask

    task automatic test_range_error();
        set_pos(0, 0);
        wr_valid = 1'b1;
        wr_addr  = 18'd196608;
        wr_data  = 24'h123456;
        #1;
        total++; if (wr_err !== 1'b0) $display("FAIL rng_err_pre got=%b exp=0", wr_err); else passed++;
        tick();
        wr_valid = 1'b0;
        total++; if (ram_we !== 1'b0) $display("FAIL rng_we0 got=%b exp=0", ram_we); else passed++;
        tick();
        total++; if (ram_we !== 1'b0) $display("FAIL rng_we1 got=%b exp=0", ram_we); else passed++;
        total++; if (wr_err !== 1'b1) $display("FAIL rng_err got=%b exp=1", wr_err); else passed++;
        set_pos(3, 3);
        for (int i = 0; i < 3; i++) tick();
        set_pos(0, 0);
        tick();
        total++; if (wr_err !== 1'b1) $display("FAIL rng_err_sticky got=%b exp=1", wr_err); else passed++;
    endtask

`ifdef FRAME_WR_FIFO_EN
    task automatic test_fifo();
        set_pos(20, 2);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 18'(200 + i);
            wr_data  = 24'(24'h100000 + i);
            #1;
            if (i < 4) begin
                total++; if (wr_ready !== 1'b1) $display("FAIL fifo_ready%0d got=%b exp=1", i, wr_ready); else passed++;
                tick();
                total++; if (ram_we !== 1'b0) $display("FAIL fifo_we_win%0d got=%b exp=0", i, ram_we); else passed++;
            end else begin
                total++; if (wr_ready !== 1'b0) $display("FAIL fifo_full got=%b exp=0", wr_ready); else passed++;
            end
        end
        // 5th write is held by the writer; blanking starts the drain.
        set_pos(0, 0);
        #1;
        total++; if (wr_ready !== 1'b0) $display("FAIL fifo_full_blank got=%b exp=0", wr_ready); else passed++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) wr_valid = 1'b0;
            total++; if (ram_we !== 1'b1) $display("FAIL fifo_drain_we%0d got=%b exp=1", k, ram_we); else passed++;
            total++; if (ram_addr !== 18'(200 + k)) $display("FAIL fifo_drain_addr%0d got=%0d exp=%0d", k, ram_addr, 200 + k); else passed++;
            total++; if (ram_din !== 24'(24'h100000 + k)) $display("FAIL fifo_drain_din%0d got=%h exp=%h", k, ram_din, 24'h100000 + k); else passed++;
            if (k == 0) begin
                total++; if (wr_ready !== 1'b1) $display("FAIL fifo_ready_after_pop got=%b exp=1", wr_ready); else passed++;
            end
        end
        tick();
        total++; if (ram_we !== 1'b0) $display("FAIL fifo_empty_we got=%b exp=0", ram_we); else passed++;
    endtask
`endif

    task automatic test_reset_mid_frame();
        set_pos(5, 5);
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b0;
        #1;
        total++; if (pix_out !== '0) $display("FAIL mid_rst_pix got=%h exp=0", pix_out); else passed++;
        total++; if (ram_addr !== '0) $display("FAIL mid_rst_addr got=%h exp=0", ram_addr); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL mid_rst_we got=%b exp=0", ram_we); else passed++;
        total++; if (ram_din !== '0) $display("FAIL mid_rst_din got=%h exp=0", ram_din); else passed++;
        total++; if (wr_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", wr_ready); else passed++;
        total++; if (wr_err !== 1'b0) $display("FAIL mid_rst_err got=%b exp=0", wr_err); else passed++;
        set_pos(7, 3);   // address 6 + 2*512 = 1030
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++; if (pix_out !== '0) $display("FAIL mid_pix_c1 got=%h exp=0", pix_out); else passed++;
        tick();
        total++; if (pix_out !== '0) $display("FAIL mid_pix_c2 got=%h exp=0", pix_out); else passed++;
        tick();
        total++; if (pix_out !== {6'h2A, 18'd1030}) $display("FAIL mid_pix_c3 got=%h exp=%h", pix_out, {6'h2A, 18'd1030}); else passed++;
    endtask

    initial begin
        test_reset();
        test_read_addr();
        test_out_of_window();
        test_contention();
        test_range_error();
`ifdef FRAME_WR_FIFO_EN
        test_fifo();
`endif
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
